// File: rtl/mem_copy_engine.sv
// Word-granular block-copy initiator that owns the data-memory port while busy.
// Optional MEMCPY_FILL_EN adds a pattern-fill mode (fill_mode/fill_data) that skips reads.
module mem_copy_engine #(
  parameter int MEM_BYTES = 1024,
  parameter int LEN_W     = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
`ifdef MEMCPY_FILL_EN
  input  logic             fill_mode,
  input  logic [31:0]      fill_data,
`endif
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);

  localparam logic [33:0] MEM_LIMIT = 34'(MEM_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t           r_state, w_state_next;
  logic [31:0]      r_src, r_dst, r_buf;
  logic [LEN_W-1:0] r_len, r_idx;
  logic             r_err;

  logic             w_fill_req, w_fill;
  logic [31:0]      w_fill_word;
  logic [33:0]      w_span, w_src_end, w_dst_end;
  logic             w_bad_src, w_bad_dst, w_reject, w_last;
  logic [31:0]      w_offset;

`ifdef MEMCPY_FILL_EN
  logic        r_fill;
  logic [31:0] r_fill_data;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fill      <= 1'b0;
      r_fill_data <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_fill      <= fill_mode;
      r_fill_data <= fill_data;
    end
  end

  assign w_fill_req  = fill_mode;
  assign w_fill      = r_fill;
  assign w_fill_word = r_fill_data;
`else
  assign w_fill_req  = 1'b0;
  assign w_fill      = 1'b0;
  assign w_fill_word = '0;
`endif

  // 34-bit end addresses so a huge base plus length cannot wrap into range.
  assign w_span    = 34'({len, 2'b00});
  assign w_src_end = {2'b00, src_addr} + w_span;
  assign w_dst_end = {2'b00, dst_addr} + w_span;
  assign w_bad_src = !w_fill_req && ((src_addr[1:0] != 2'b00) || (w_src_end > MEM_LIMIT));
  assign w_bad_dst = (dst_addr[1:0] != 2'b00) || (w_dst_end > MEM_LIMIT);
  assign w_reject  = w_bad_src || w_bad_dst;
  assign w_offset  = 32'({r_idx, 2'b00});
  assign w_last    = (r_idx == r_len - LEN_W'(1));
  assign err       = r_err;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (len == '0 || w_reject) w_state_next = S_DONE;
          else if (w_fill_req)       w_state_next = S_WRITE;
          else                       w_state_next = S_READ;
        end
      end
      S_READ: begin
        busy         = 1'b1;
        mem_rd       = 1'b1;
        mem_addr     = r_src + w_offset;
        w_state_next = S_WRITE;
      end
      S_WRITE: begin
        busy      = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = r_dst + w_offset;
        mem_wdata = w_fill ? w_fill_word : r_buf;
        if (w_last)      w_state_next = S_DONE;
        else if (w_fill) w_state_next = S_WRITE;
        else             w_state_next = S_READ;
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_src <= '0;
      r_dst <= '0;
      r_len <= '0;
      r_idx <= '0;
      r_buf <= '0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_src <= src_addr;
            r_dst <= dst_addr;
            r_len <= len;
            r_idx <= '0;
            r_err <= (len != '0) && w_reject;
          end
        end
        S_READ:  r_buf <= mem_rdata;
        S_WRITE: if (!w_last) r_idx <= r_idx + LEN_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_copy_engine.md
# mem_copy_engine

Word-granular block-copy initiator that drives the data-memory port (rd/wr/addr/wdata/rdata) from the master side. On a start pulse it moves a run of 32-bit words from a source region to a destination region in ascending order, then signals completion. It sits between the CPU control logic and the data memory and owns the memory port while busy; the CPU must not drive the port during that time.

## Interface
Parameters:
- MEM_BYTES, 1024: addressable data-memory size in bytes; valid addresses are 0..MEM_BYTES-1.
- LEN_W, 9: width of the word-count field; maximum transfer is 2^LEN_W-1 words.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- src_addr  in  32  source byte address; must be word aligned.
- dst_addr  in  32  destination byte address; must be word aligned.
- len  in  LEN_W  number of words to move.
- busy  out  1  high in READ and WRITE states.
- done  out  1  one-cycle completion pulse.
- err  out  1  last request rejected; held until the next accepted start.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_addr  out  32  memory byte address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; combinational from mem_addr while mem_rd=1.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: when start=1, latch src_addr, dst_addr and len, and clear the word index i.
  - If len=0, go to DONE with err=0.
  - If src_addr[1:0]!=0 or dst_addr[1:0]!=0, go to DONE with err=1.
  - If src_addr+4*len > MEM_BYTES or dst_addr+4*len > MEM_BYTES, go to DONE with err=1. The range check uses 34-bit arithmetic, so there is no wrap-around.
  - Otherwise go to READ with err=0.
- READ: mem_rd=1, mem_addr=src+4*i. At the clock edge, capture mem_rdata into the data buffer, then go to WRITE.
- WRITE: mem_wr=1, mem_addr=dst+4*i, mem_wdata=buffer.
  - If i=len-1, go to DONE.
  - Otherwise i<=i+1 and go to READ.
- DONE: done=1 for one cycle, then go to IDLE.
- Overlapping regions: each word is read and then written, in ascending index order. If dst>src and the regions overlap, the source is overwritten before it is read; this is the defined behaviour, not an error.
- start is ignored outside IDLE, and inputs are not resampled mid-transfer.
- Outside READ/WRITE: mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0.

## Timing
- Reset (reset=0 at an edge): state becomes IDLE; busy, done, err, mem_rd and mem_wr are 0; mem_addr and mem_wdata are 0. The index and buffer are cleared.
- Reset mid-transfer aborts the transfer. Words already written stay written, and no done pulse is issued.
- Start accepted at edge E0:
  - First READ cycle is the cycle after E0.
  - Valid copy: two cycles per word; the last WRITE is in cycle 2*len after E0 and done is high in cycle 2*len+1.
  - Rejected request or len=0: done is high in cycle 1, with no memory strobes at any point.
- err updates together with the transition out of IDLE, and is stable by the time done is asserted.
- Back-to-back use: start may be held high. It is next sampled in the IDLE cycle after DONE, so there is one idle cycle minimum between transfers.

## Configuration
- MEMCPY_FILL_EN defined:
  - Adds inputs fill_mode (1 bit) and fill_data (32 bits), both latched at start.
  - If fill_mode=1, READ is skipped and src_addr is neither checked nor used. WRITE repeats every cycle with mem_wdata=fill_data. done comes in cycle len+1.
  - Alignment and range checks apply to dst_addr only.
- MEMCPY_FILL_EN undefined: the fill_mode and fill_data ports do not exist, and the block performs copies only.

## Test plan
- Copy, len=4, src=0x000, dst=0x100, memory preloaded with 0x11, 0x22, 0x33, 0x44 -> words 0x100..0x10C hold the same values in order; busy is high in cycles 1-8; done is high in cycle 9; err=0.
- len=0 -> done in cycle 1, err=0, no mem_rd or mem_wr ever high.
- src=0x002, len=2 -> done in cycle 1, err=1, no strobes; the next valid start clears err.
- dst=0x3F8, len=4 (ends at 0x408 > 1024) -> err=1, no strobes. dst=0x3F0, len=4 -> accepted and completes.
- Reset driven to 0 during the WRITE of word 2 in a len=5 copy -> all outputs are 0 at the next edge; only words 0-1 (plus word 2 if the write edge coincided) are written; no done pulse.
- With MEMCPY_FILL_EN: fill_mode=1, dst=0x40, len=3, fill_data=0xDEADBEEF -> writes to 0x40, 0x44, 0x48 in cycles 1-3; mem_rd never high; done in cycle 4.
